ev3a_pop_streamer: RTL

//  Host-side transmitter for the EV3a evolutionary core. Buffers a host-written population
//  (lattice state + mutation rate per individual) and a run configuration, then streams them

---
 rtl/ev3a_pkg.sv | 42 ++++
 rtl/ev3a_pop_streamer_if.sv | 53 +++++
 rtl/ev3a_pop_buf.sv | 36 +++
 rtl/ev3a_pop_streamer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ev3a_pkg.sv
// ----------------------------------------------------------------------------
// ev3a_pkg
// Shared definitions for the EV3a population streamer slice.
//   - default field widths of the EV3a core interface
//   - streamer FSM state encoding
//   - individual / result record layouts
//   - population-size range check used when a run is started
// ----------------------------------------------------------------------------
package ev3a_pkg;

    localparam int INT8_W        = 8;   // generations, crossover fraction, pop size, mutation rate
    localparam int ENERGY_W      = 4;   // self / interaction energy
    localparam int PARTICLE_W    = 2;   // bits per lattice site
    localparam int LATTICE_SITES = 11;  // lattice sites per individual
    localparam int FIT_W         = 10;  // fitness
    localparam int POP_DEPTH     = 32;  // population buffer depth (power of two)
    localparam int STATE_W       = PARTICLE_W * LATTICE_SITES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [INT8_W-1:0]  mut;
    } ind_t;

    typedef struct packed {
        logic [FIT_W-1:0]   fit;
        logic [STATE_W-1:0] state;
        logic [INT8_W-1:0]  mut;
    } result_t;

    // A run needs at least one individual and no more than the buffer holds.
    function automatic logic pop_valid(input logic [INT8_W-1:0] pop, input int max_pop);
        return (pop != '0) && (int'(pop) <= max_pop);
    endfunction

endpackage

// File: rtl/ev3a_pop_streamer_if.sv
// ----------------------------------------------------------------------------
// ev3a_pop_streamer_if
// Link between the population streamer and the EV3a core.
//   master (streamer): drives in_valid, ind_state_in, Mutate_rate_in and the
//                      latched run configuration; receives the core result.
//   slave  (core)    : the reverse view.
// Signals:
//   in_valid, ind_state_in, Mutate_rate_in         individual stream to core
//   Num_generations, crossoverFraction, Pop_size,
//   self_energy, interact_energy, Num_particleType run configuration to core
//   Min_fit_out, Best_ind_state, Best_ind_mut, done core result
// ----------------------------------------------------------------------------
interface ev3a_pop_streamer_if
    import ev3a_pkg::*;
#(
    parameter int INT8_LENGTH     = INT8_W,
    parameter int ENERGY_LENGTH   = ENERGY_W,
    parameter int PARTICLE_LENGTH = PARTICLE_W,
    parameter int LATTICE_LENGTH  = LATTICE_SITES,
    parameter int IND_FIT_LENGTH  = FIT_W
);

    logic                                      in_valid;
    logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] ind_state_in;
    logic [INT8_LENGTH-1:0]                    Mutate_rate_in;

    logic [INT8_LENGTH-1:0]                    Num_generations;
    logic [INT8_LENGTH-1:0]                    crossoverFraction;
    logic [INT8_LENGTH-1:0]                    Pop_size;
    logic [ENERGY_LENGTH-1:0]                  self_energy;
    logic [ENERGY_LENGTH-1:0]                  interact_energy;
    logic [PARTICLE_LENGTH-1:0]                Num_particleType;

    logic [IND_FIT_LENGTH-1:0]                 Min_fit_out;
    logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] Best_ind_state;
    logic [INT8_LENGTH-1:0]                    Best_ind_mut;
    logic                                      done;

    modport master (
        output in_valid, ind_state_in, Mutate_rate_in,
        output Num_generations, crossoverFraction, Pop_size,
        output self_energy, interact_energy, Num_particleType,
        input  Min_fit_out, Best_ind_state, Best_ind_mut, done
    );

    modport slave (
        input  in_valid, ind_state_in, Mutate_rate_in,
        input  Num_generations, crossoverFraction, Pop_size,
        input  self_energy, interact_energy, Num_particleType,
        output Min_fit_out, Best_ind_state, Best_ind_mut, done
    );

endinterface

// File: rtl/ev3a_pop_buf.sv
// ----------------------------------------------------------------------------
// ev3a_pop_buf
// Population buffer: DEPTH-entry, one write port, one read port.
// Synchronous write, registered read (data appears the cycle after rd_addr).
// Contents are not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   entry to store
//   rd_addr  in   read index
//   rd_data  out  registered read data
// ----------------------------------------------------------------------------
module ev3a_pop_buf #(
    parameter int DEPTH = 32,
    parameter int DW    = 30,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ev3a_pop_streamer.sv
// ----------------------------------------------------------------------------
// ev3a_pop_streamer
// Host-side transmitter for the EV3a evolutionary core. The host fills the
// population buffer and presents a run configuration; on start the block
// latches the configuration, streams Pop_size individuals into the core,
// waits for done, captures the core result and hands it back to the host
// over a valid/ready handshake.
//
// Optional feature: define EV3A_STREAM_TIMEOUT_EN to enable a WAIT watchdog
// (TIMEOUT_CYCLES); on expiry a synthetic result (fit all-ones, state/mut 0,
// res_timeout=1) is returned. Without it WAIT never times out and
// res_timeout is tied low.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_en/wr_addr/wr_state/wr_mut   host buffer write (ignored while busy)
//   cfg_gens/cfg_xfrac/cfg_pop/cfg_self_e/cfg_int_e/cfg_ptypes  run config
//   start                      start-run pulse (ignored while busy)
//   busy                       high outside IDLE
//   cfg_err                    one-cycle pulse when start is rejected
//   core (master)              individual stream, latched config, core result
//   res_valid/res_ready        result handshake to host
//   res_fit/res_state/res_mut  captured result
//   res_timeout                result was produced by the watchdog
// ----------------------------------------------------------------------------
module ev3a_pop_streamer
    import ev3a_pkg::*;
#(
    parameter int INT8_LENGTH     = INT8_W,
    parameter int ENERGY_LENGTH   = ENERGY_W,
    parameter int PARTICLE_LENGTH = PARTICLE_W,
    parameter int LATTICE_LENGTH  = LATTICE_SITES,
    parameter int IND_FIT_LENGTH  = FIT_W,
    parameter int MAX_POP         = POP_DEPTH
`ifdef EV3A_STREAM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 65535
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst_n,

    input  logic                                      wr_en,
    input  logic [$clog2(MAX_POP)-1:0]                wr_addr,
    input  logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] wr_state,
    input  logic [INT8_LENGTH-1:0]                    wr_mut,

    input  logic [INT8_LENGTH-1:0]                    cfg_gens,
    input  logic [INT8_LENGTH-1:0]                    cfg_xfrac,
    input  logic [INT8_LENGTH-1:0]                    cfg_pop,
    input  logic [ENERGY_LENGTH-1:0]                  cfg_self_e,
    input  logic [ENERGY_LENGTH-1:0]                  cfg_int_e,
    input  logic [PARTICLE_LENGTH-1:0]                cfg_ptypes,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      cfg_err,

    ev3a_pop_streamer_if.master                       core,

    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [IND_FIT_LENGTH-1:0]                 res_fit,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] res_state,
    output logic [INT8_LENGTH-1:0]                    res_mut,
    output logic                                      res_timeout
);

    localparam int AW = $clog2(MAX_POP);
    localparam int SW = PARTICLE_LENGTH * LATTICE_LENGTH;
    localparam int DW = SW + INT8_LENGTH;

    state_e                 state;
    logic [INT8_LENGTH-1:0] idx_q;      // index of the individual currently on the stream
    logic                   idle;
    logic                   last_ind;
    logic                   buf_we;
    logic [AW-1:0]          rd_addr;
    logic [DW-1:0]          rd_data;

    assign idle     = (state == ST_IDLE);
    assign busy     = ~idle;
    assign buf_we   = idle & wr_en;
    assign last_ind = (idx_q == core.Pop_size - 1'b1);

    // The buffer read is registered, so the address runs one entry ahead of
    // the individual on the stream: entry 0 is fetched during the accepting
    // IDLE cycle, entry k+1 while entry k is presented.
    assign rd_addr = idle ? '0 : AW'(idx_q + 1'b1);

    ev3a_pop_buf #(
        .DEPTH (MAX_POP),
        .DW    (DW),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data ({wr_state, wr_mut}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign core.in_valid       = (state == ST_STREAM);
    assign core.ind_state_in   = core.in_valid ? rd_data[DW-1:INT8_LENGTH] : '0;
    assign core.Mutate_rate_in = core.in_valid ? rd_data[INT8_LENGTH-1:0]  : '0;

`ifdef EV3A_STREAM_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCW-1:0] wait_cnt;
    logic           wait_expired;

    // Counter rests at zero outside WAIT, so it is cleared on every WAIT entry.
    assign wait_expired = (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= ST_IDLE;
            idx_q                  <= '0;
            cfg_err                <= 1'b0;
            core.Num_generations   <= '0;
            core.crossoverFraction <= '0;
            core.Pop_size          <= '0;
            core.self_energy       <= '0;
            core.interact_energy   <= '0;
            core.Num_particleType  <= '0;
            res_valid              <= 1'b0;
            res_fit                <= '0;
            res_state              <= '0;
            res_mut                <= '0;
`ifdef EV3A_STREAM_TIMEOUT_EN
            res_timeout            <= 1'b0;
`endif
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (pop_valid(cfg_pop, MAX_POP)) begin
                            core.Num_generations   <= cfg_gens;
                            core.crossoverFraction <= cfg_xfrac;
                            core.Pop_size          <= cfg_pop;
                            core.self_energy       <= cfg_self_e;
                            core.interact_energy   <= cfg_int_e;
                            core.Num_particleType  <= cfg_ptypes;
                            idx_q                  <= '0;
                            state                  <= ST_STREAM;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                ST_STREAM: begin
                    if (last_ind) begin
                        idx_q <= '0;
                        state <= ST_WAIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    // done has priority over a watchdog expiry in the same cycle.
                    if (core.done) begin
                        res_fit   <= core.Min_fit_out;
                        res_state <= core.Best_ind_state;
                        res_mut   <= core.Best_ind_mut;
                        res_valid <= 1'b1;
                        state     <= ST_RESULT;
`ifdef EV3A_STREAM_TIMEOUT_EN
                        res_timeout <= 1'b0;
                    end else if (wait_expired) begin
                        res_fit     <= '1;
                        res_state   <= '0;
                        res_mut     <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_RESULT;
`endif
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
